// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer controller and its alarm blinker.
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_e;

  localparam logic [1:0] STATE_IDLE  = 2'b00;
  localparam logic [1:0] STATE_RUN   = 2'b01;
  localparam logic [1:0] STATE_PAUSE = 2'b10;
  localparam logic [1:0] STATE_DONE  = 2'b11;

  localparam logic [1:0] MODE_30S  = 2'b00;
  localparam logic [1:0] MODE_100S = 2'b01;

  localparam int BLINK_CNT_W = 8;

  // LOAD is a hidden transient, so the display sees it as IDLE.
  function automatic logic [1:0] encodeState(input ctrl_state_e s);
    logic [1:0] enc;
    enc = STATE_IDLE;
    case (s)
      ST_RUN:   enc = STATE_RUN;
      ST_PAUSE: enc = STATE_PAUSE;
      ST_DONE:  enc = STATE_DONE;
      default:  enc = STATE_IDLE;
    endcase
    return enc;
  endfunction

  function automatic logic digitsZero(input logic [3:0] d0, input logic [3:0] d1,
                                      input logic [3:0] d2, input logic [3:0] d3);
    return (d0 == 4'd0) && (d1 == 4'd0) && (d2 == 4'd0) && (d3 == 4'd0);
  endfunction

  // Digits {min tens, min units, sec tens, sec units} the counter loads for a mode.
  function automatic logic [15:0] presetDigits(input logic [1:0] m);
    logic [15:0] p;
    p = 16'h0000;
    if (m == MODE_30S) begin
      p = 16'h0030;
    end else if (m == MODE_100S) begin
      p = 16'h0100;
    end
    return p;
  endfunction

endpackage

// File: rtl/alarm_blink.sv
// Expiry alarm: blinks while run is high and reports when the toggle budget is used up.
module alarm_blink
  import timer_pkg::*;
#(
  parameter int BLINK_HALF    = 25,
  parameter int ALARM_TOGGLES = 20
) (
  input  logic clk_out,
  input  logic rst_n,
  input  logic run,
  output logic alarm,
  output logic expired
);

  localparam logic [BLINK_CNT_W-1:0] HALF_LAST    = BLINK_CNT_W'(BLINK_HALF - 1);
  localparam logic [BLINK_CNT_W-1:0] TOGGLE_LIMIT = BLINK_CNT_W'(ALARM_TOGGLES);

  logic [BLINK_CNT_W-1:0] divCnt_q, divCnt_d;
  logic [BLINK_CNT_W-1:0] toggleCnt_q, toggleCnt_d;
  logic                   alarm_q, alarm_d;
  logic                   active_q, active_d;

  // The rising edge of alarm on entry counts as the first toggle.
  always_comb begin
    divCnt_d    = divCnt_q;
    toggleCnt_d = toggleCnt_q;
    alarm_d     = alarm_q;
    active_d    = active_q;
    if (!run) begin
      divCnt_d    = '0;
      toggleCnt_d = '0;
      alarm_d     = 1'b0;
      active_d    = 1'b0;
    end else if (!active_q) begin
      divCnt_d    = '0;
      toggleCnt_d = BLINK_CNT_W'(1);
      alarm_d     = 1'b1;
      active_d    = 1'b1;
    end else if (divCnt_q == HALF_LAST) begin
      divCnt_d = '0;
      alarm_d  = ~alarm_q;
      if (toggleCnt_q != TOGGLE_LIMIT) begin
        toggleCnt_d = toggleCnt_q + BLINK_CNT_W'(1);
      end
    end else begin
      divCnt_d = divCnt_q + BLINK_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_out) begin
    if (!rst_n) begin
      divCnt_q    <= '0;
      toggleCnt_q <= '0;
      alarm_q     <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      divCnt_q    <= divCnt_d;
      toggleCnt_q <= toggleCnt_d;
      alarm_q     <= alarm_d;
      active_q    <= active_d;
    end
  end

  assign alarm   = alarm_q;
  assign expired = active_q && (toggleCnt_q == TOGGLE_LIMIT);

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer controller: sequences preset load, run/pause and the expiry alarm
// for an external BCD digit counter.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int BLINK_HALF    = 25,
  parameter int ALARM_TOGGLES = 20
) (
  input  logic       clk_out,
  input  logic       rst_n,
  input  logic       start_pls,
  input  logic       clear_pls,
  input  logic [1:0] mode_sel,
  input  logic [3:0] c0,
  input  logic [3:0] c1,
  input  logic [3:0] c2,
  input  logic [3:0] c3,
  output logic       en,
  output logic [1:0] mode,
  output logic       cnt_load_n,
  output logic       alarm,
  output logic [1:0] state
);

  ctrl_state_e state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic        loadFromStart_q, loadFromStart_d;
  logic        en_q;
  logic        loadN_q;
  logic [1:0]  stateEnc_q;
  logic        atZero;
  logic        alarmExpired;
  logic        alarmRun;

  assign atZero = digitsZero(c0, c1, c2, c3);

  // Clear wins over everything; loadFromStart remembers where LOAD should exit to.
  always_comb begin
    state_d         = state_q;
    mode_d          = mode_q;
    loadFromStart_d = loadFromStart_q;
    if (clear_pls) begin
      state_d         = ST_LOAD;
      mode_d          = mode_sel;
      loadFromStart_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_pls) begin
            state_d         = ST_LOAD;
            mode_d          = mode_sel;
            loadFromStart_d = 1'b1;
          end
        end
        ST_LOAD: begin
          state_d = loadFromStart_q ? ST_RUN : ST_IDLE;
        end
        ST_RUN: begin
          if (atZero) begin
            state_d = ST_DONE;
          end else if (start_pls) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (start_pls) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (start_pls || alarmExpired) begin
            state_d         = ST_LOAD;
            loadFromStart_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they move on the same edge as the FSM.
  always_ff @(posedge clk_out) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      mode_q          <= MODE_30S;
      loadFromStart_q <= 1'b0;
      en_q            <= 1'b0;
      loadN_q         <= 1'b0;
      stateEnc_q      <= STATE_IDLE;
    end else begin
      state_q         <= state_d;
      mode_q          <= mode_d;
      loadFromStart_q <= loadFromStart_d;
      en_q            <= (state_d == ST_RUN);
      loadN_q         <= (state_d != ST_LOAD);
      stateEnc_q      <= encodeState(state_d);
    end
  end

  assign alarmRun = (state_d == ST_DONE);

  alarm_blink #(
    .BLINK_HALF   (BLINK_HALF),
    .ALARM_TOGGLES(ALARM_TOGGLES)
  ) u_alarm_blink (
    .clk_out(clk_out),
    .rst_n  (rst_n),
    .run    (alarmRun),
    .alarm  (alarm),
    .expired(alarmExpired)
  );

  assign en         = en_q;
  assign mode       = mode_q;
  assign cnt_load_n = loadN_q;
  assign state      = stateEnc_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a behavioural mm:ss down-counter wrapped around it.
module tb_timer_ctrl;

  logic       clk_out = 1'b0;
  logic       rst_n;
  logic       start_pls;
  logic       clear_pls;
  logic [1:0] mode_sel;
  logic [3:0] c0 = 4'd0;
  logic [3:0] c1 = 4'd0;
  logic [3:0] c2 = 4'd0;
  logic [3:0] c3 = 4'd0;
  logic       en;
  logic [1:0] mode;
  logic       cnt_load_n;
  logic       alarm;
  logic [1:0] state;

  int compareCount = 0;
  int failCount    = 0;

  timer_ctrl #(
    .BLINK_HALF   (2),
    .ALARM_TOGGLES(4)
  ) dut (
    .clk_out   (clk_out),
    .rst_n     (rst_n),
    .start_pls (start_pls),
    .clear_pls (clear_pls),
    .mode_sel  (mode_sel),
    .c0        (c0),
    .c1        (c1),
    .c2        (c2),
    .c3        (c3),
    .en        (en),
    .mode      (mode),
    .cnt_load_n(cnt_load_n),
    .alarm     (alarm),
    .state     (state)
  );

  always #5 clk_out = ~clk_out;

  // External counter: synchronous preset load, saturating BCD mm:ss countdown.
  always @(posedge clk_out) begin
    if (cnt_load_n == 1'b0) begin
      c3 <= 4'd0;
      c2 <= (mode == 2'b01) ? 4'd1 : 4'd0;
      c1 <= (mode == 2'b00) ? 4'd3 : 4'd0;
      c0 <= 4'd0;
    end else if (en == 1'b1 && {c3, c2, c1, c0} != 16'h0000) begin
      if (c0 != 4'd0) begin
        c0 <= c0 - 4'd1;
      end else begin
        c0 <= 4'd9;
        if (c1 != 4'd0) begin
          c1 <= c1 - 4'd1;
        end else begin
          c1 <= 4'd5;
          if (c2 != 4'd0) begin
            c2 <= c2 - 4'd1;
          end else begin
            c2 <= 4'd9;
            c3 <= c3 - 4'd1;
          end
        end
      end
    end
  end

  typedef struct {
    logic       start;
    logic       clear;
    logic [1:0] modeSel;
    int         expState;
    int         expEn;
    int         expLoadN;
    int         expMode;
    int         expAlarm;
  } vec_t;

  vec_t vecs[13];

  // One clock of stimulus: inputs set at a falling edge, outputs valid at the next one.
  task automatic applyStimulus(input logic s, input logic c, input logic [1:0] m);
    start_pls = s;
    clear_pls = c;
    mode_sel  = m;
    @(posedge clk_out);
    @(negedge clk_out);
    start_pls = 1'b0;
    clear_pls = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    compareCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int s, input int e, input int l, input int m,
                          input int a);
    checkOutput({tag, ".state"}, int'(state), s);
    checkOutput({tag, ".en"}, int'(en), e);
    checkOutput({tag, ".cnt_load_n"}, int'(cnt_load_n), l);
    checkOutput({tag, ".mode"}, int'(mode), m);
    checkOutput({tag, ".alarm"}, int'(alarm), a);
  endtask

  // Call while in the first observed RUN cycle; returns how many cycles RUN lasted.
  task automatic runUntilDone(output int runCycles);
    runCycles = 1;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b0, 1'b0, mode_sel);
      if (state != 2'b01) break;
      runCycles++;
    end
  endtask

  initial begin
    int runCycles;
    logic [5:0] blinkPat;

    vecs[0]  = '{1'b0, 1'b0, 2'b00, 0, 0, 1, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 2'b01, 0, 0, 0, 1, 0};
    vecs[2]  = '{1'b0, 1'b0, 2'b00, 0, 0, 1, 1, 0};
    vecs[3]  = '{1'b1, 1'b0, 2'b00, 0, 0, 0, 0, 0};
    vecs[4]  = '{1'b0, 1'b0, 2'b11, 1, 1, 1, 0, 0};
    vecs[5]  = '{1'b0, 1'b0, 2'b11, 1, 1, 1, 0, 0};
    vecs[6]  = '{1'b1, 1'b0, 2'b11, 2, 0, 1, 0, 0};
    vecs[7]  = '{1'b0, 1'b0, 2'b11, 2, 0, 1, 0, 0};
    vecs[8]  = '{1'b1, 1'b0, 2'b01, 1, 1, 1, 0, 0};
    vecs[9]  = '{1'b1, 1'b1, 2'b01, 0, 0, 0, 1, 0};
    vecs[10] = '{1'b0, 1'b0, 2'b00, 0, 0, 1, 1, 0};
    vecs[11] = '{1'b1, 1'b1, 2'b10, 0, 0, 0, 2, 0};
    vecs[12] = '{1'b0, 1'b0, 2'b00, 0, 0, 1, 2, 0};

    rst_n     = 1'b0;
    start_pls = 1'b0;
    clear_pls = 1'b0;
    mode_sel  = 2'b11;
    applyStimulus(1'b0, 1'b0, 2'b11);
    applyStimulus(1'b1, 1'b0, 2'b11);
    checkAll("reset", 0, 0, 0, 0, 0);

    rst_n = 1'b1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].start, vecs[i].clear, vecs[i].modeSel);
      checkAll($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expEn, vecs[i].expLoadN,
               vecs[i].expMode, vecs[i].expAlarm);
    end

    $display("[TB] full countdown from 0:30");
    applyStimulus(1'b1, 1'b0, 2'b00);
    checkAll("cd.load", 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkAll("cd.run1", 1, 1, 1, 0, 0);
    checkOutput("cd.digits", int'({c3, c2, c1, c0}), 'h0030);
    runUntilDone(runCycles);
    checkOutput("cd.runCycles", runCycles, 31);
    checkAll("cd.done", 3, 0, 1, 0, 1);
    applyStimulus(1'b1, 1'b0, 2'b00);
    checkAll("cd.stopLoad", 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkAll("cd.idle", 0, 0, 1, 0, 0);

    $display("[TB] pause/resume and alarm auto-exit");
    applyStimulus(1'b1, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("pr.preDigits", int'({c3, c2, c1, c0}), 'h0021);
    applyStimulus(1'b1, 1'b0, 2'b00);
    checkAll("pr.pause", 2, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("pr.frozenState", int'(state), 2);
    checkOutput("pr.frozenDigits", int'({c3, c2, c1, c0}), 'h0020);
    applyStimulus(1'b1, 1'b0, 2'b00);
    checkAll("pr.resume", 1, 1, 1, 0, 0);
    checkOutput("pr.resumeDigits", int'({c3, c2, c1, c0}), 'h0020);
    runUntilDone(runCycles);
    checkOutput("pr.runCycles", runCycles, 21);
    checkAll("pr.done1", 3, 0, 1, 0, 1);
    blinkPat = 6'b100110;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 2'b00);
      checkOutput($sformatf("pr.blinkState%0d", i + 2), int'(state), 3);
      checkOutput($sformatf("pr.blink%0d", i + 2), int'(alarm), int'(blinkPat[5-i]));
    end
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkAll("pr.autoLoad", 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkAll("pr.autoIdle", 0, 0, 1, 0, 0);

    $display("[TB] zero preset");
    applyStimulus(1'b1, 1'b0, 2'b11);
    checkAll("zp.load", 0, 0, 0, 3, 0);
    applyStimulus(1'b0, 1'b0, 2'b11);
    checkAll("zp.run", 1, 1, 1, 3, 0);
    applyStimulus(1'b0, 1'b0, 2'b11);
    checkAll("zp.done", 3, 0, 1, 3, 1);
    applyStimulus(1'b1, 1'b0, 2'b11);
    checkAll("zp.stopLoad", 0, 0, 0, 3, 0);
    applyStimulus(1'b0, 1'b0, 2'b11);
    checkAll("zp.idle", 0, 0, 1, 3, 0);

    $display("[TB] reset during RUN");
    applyStimulus(1'b1, 1'b0, 2'b01);
    applyStimulus(1'b0, 1'b0, 2'b01);
    applyStimulus(1'b0, 1'b0, 2'b01);
    checkAll("rr.running", 1, 1, 1, 1, 0);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b01);
    checkAll("rr.inReset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'b01);
    checkAll("rr.released", 0, 0, 1, 0, 0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
